countdown_timer_halfsub: RTL and testbench
==========================================

Name: countdown_timer_halfsub

Overview:
- Loadable down-counter and timer: the decrementing counterpart of the team's half-adder up-counter.
- The next-count value comes from a ripple chain of half-subtractors (diff = a ^ b, borrow = ~a & b), with a constant 1 fed into the LSB.
- A small control FSM handles load, start, stop and auto-reload.
- Drives a one-cycle `done` pulse when the count expires; used as a programmable delay or tick generator beside the up-counter.

Parameters:
- WIDTH, 4, counter and reload width in bits (legal range 2..16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  when high, copy load_val into cnt and reload_reg; aborts any run.
- load_val  in  WIDTH  value to load.
- start  in  1  IDLE->RUN request.
- stop  in  1  RUN->IDLE request; cnt holds its value.
- en  in  1  count enable (tick qualifier) while in RUN.
- auto_reload  in  1  sampled at expiry; 1 reloads from reload_reg and keeps running.
- cnt  out  WIDTH  current count (registered).
- busy  out  1  high while FSM is in RUN.
- done  out  1  one-cycle expiry pulse (registered).

Behaviour:
- Reset (async, rst=1): cnt=0, reload_reg=0, state=IDLE, busy=0, done=0. Outputs hold these values until the first clk edge after rst falls.
- Decrement datapath:
  - WIDTH half-subtractors; stage 0 subtracts 1, stage n subtracts borrow[n-1].
  - The final borrow is unused internally.
  - Pure decrement, no saturation: 0 - 1 wraps to 2^WIDTH-1, but the FSM never decrements from 0.
- FSM states IDLE and RUN. Per-edge priority, highest first: load > stop > start > counting.
- load=1, any state:
  - cnt <= load_val, reload_reg <= load_val.
  - state <= IDLE, done <= 0.
  - start, stop and en are ignored that cycle.
- IDLE:
  - start=1 and cnt!=0 -> RUN.
  - start=1 with cnt==0 is ignored: stays IDLE, no done.
  - cnt holds its value.
- RUN, stop=1: -> IDLE, cnt holds its value, no done.
- RUN, en=0: cnt holds its value.
- RUN, en=1, cnt>1: cnt <= cnt-1.
- RUN, en=1, cnt==1 (expiry):
  - done <= 1 for exactly one cycle.
  - auto_reload=1 and reload_reg!=0: cnt <= reload_reg, stay in RUN. Period = reload_reg enabled ticks.
  - Otherwise: cnt <= 0, state <= IDLE.
- busy is a registered decode of state==RUN; it updates on the same edge as the state change.
- done is a registered output, low in all cycles other than the one following an expiry edge. It is coincident with cnt reading 0, or reading the reload value in auto-reload mode.
- Latency: start seen at edge k puts busy high after edge k. The first decrement happens at edge k+1 if en=1.
- Mid-operation rst clears everything immediately, including a done pulse in flight.
- load_val=0 is legal and leaves the block IDLE at 0.

Test Plan:
- Reset: assert rst mid-run with cnt=5 -> cnt=0, busy=0, done=0 immediately, without waiting for a clock edge.
- One-shot, WIDTH=4:
  - Stimulus: load 3, start, en=1 continuously, auto_reload=0.
  - Required: cnt 3,2,1,0 on successive edges; done high only in the cycle cnt=0; busy drops on that same edge; cnt stays 0.
- Auto-reload:
  - Stimulus: load 2, auto_reload=1, start, en=1 for 7 cycles.
  - Required: cnt 2,1,2,1,2,1,...; done pulses every 2nd cycle, coincident with cnt=2 after reload; busy stays high.
- Enable gating:
  - Stimulus: load 4, start, en toggling 1,0,1,0,...
  - Required: cnt decrements only on en=1 edges (4,3,3,2,2,1,1,0); done fires once.
- Priority and corner cases:
  - load 15 while RUN at cnt=6 with start=1 and stop=1 -> cnt=15, IDLE, no done.
  - start with cnt=0 -> stays IDLE.
  - stop at cnt=9 -> IDLE, cnt holds 9; a later start resumes from 9.
- Max value: WIDTH=4, load 15, run to expiry -> 15 enabled ticks; every borrow-ripple transition (8->7, 4->3, 2->1) is correct; single done pulse.

Source files
------------

// File: rtl/countdown_timer_halfsub.sv
// Loadable down-counter/timer. The decrement comes from a ripple chain of half-subtractors.
// A two-state FSM handles load, start, stop, enable gating and auto-reload.
module countdown_timer_halfsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Half-subtractor chain: borrow_in[0] is the constant 1 being subtracted.
  // The borrow out of the top stage is never built because nothing uses it.
  logic [WIDTH-1:0] borrow_in;
  logic [WIDTH-1:0] cnt_dec;

  assign borrow_in[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_halfsub
      assign cnt_dec[gi] = cnt_q[gi] ^ borrow_in[gi];
      if (gi < WIDTH - 1) begin : g_borrow
        assign borrow_in[gi+1] = ~cnt_q[gi] & borrow_in[gi];
      end
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (load) begin
      cnt_d    = load_val;
      reload_d = load_val;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (cnt_q != '0)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            // Unreachable through normal operation; fall back to IDLE.
            state_d = IDLE;
          end else if (en) begin
            if (cnt_q == WIDTH'(1)) begin
              done_d = 1'b1;
              if (auto_reload && (reload_q != '0)) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = '0;
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_dec;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_countdown_timer_halfsub.sv
// Scoreboard bench for countdown_timer_halfsub: the driver queues expected outputs per cycle,
// and a monitor pops and compares them after each rising edge.
module tb_countdown_timer_halfsub;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             done;

  countdown_timer_halfsub #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .en          (en),
    .auto_reload (auto_reload),
    .cnt         (cnt),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  // Drive one cycle's inputs at the falling edge and queue the outputs expected after the next rise.
  task automatic cyc(input string tag, input logic ld, input logic [WIDTH-1:0] lv,
                     input logic st, input logic sp, input logic e, input logic ar,
                     input logic [WIDTH-1:0] ec, input logic eb, input logic ed);
    exp_t x;
    @(negedge clk);
    load = ld; load_val = lv; start = st; stop = sp; en = e; auto_reload = ar;
    x.tag = tag; x.cnt = ec; x.busy = eb; x.done = ed;
    exp_q.push_back(x);
  endtask

  task automatic check_now(input string tag, input logic [WIDTH-1:0] ec,
                           input logic eb, input logic ed);
    checks++;
    if (cnt !== ec || busy !== eb || done !== ed) begin
      errors++;
      $display("FAIL %s: got cnt=%0d busy=%0b done=%0b, expected cnt=%0d busy=%0b done=%0b",
               tag, cnt, busy, done, ec, eb, ed);
    end else begin
      $display("ok   %s: cnt=%0d busy=%0b done=%0b", tag, cnt, busy, done);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: consume one expected entry per rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check_now(x.tag, x.cnt, x.busy, x.done);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0; en = 1'b0; auto_reload = 1'b0;
    repeat (2) @(negedge clk);
    check_now("reset_state", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // One-shot from 3
    cyc("os_load3",  1, 4'd3, 0, 0, 0, 0, 4'd3, 0, 0);
    cyc("os_start",  0, 4'd0, 1, 0, 0, 0, 4'd3, 1, 0);
    cyc("os_dec2",   0, 4'd0, 0, 0, 1, 0, 4'd2, 1, 0);
    cyc("os_dec1",   0, 4'd0, 0, 0, 1, 0, 4'd1, 1, 0);
    cyc("os_expire", 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 1);
    cyc("os_hold0",  0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0);
    drain();

    // Auto-reload with period 2
    cyc("ar_load2",  1, 4'd2, 0, 0, 0, 1, 4'd2, 0, 0);
    cyc("ar_start",  0, 4'd0, 1, 0, 0, 1, 4'd2, 1, 0);
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) cyc("ar_dec1",   0, 4'd0, 0, 0, 1, 1, 4'd1, 1, 0);
      else            cyc("ar_reload", 0, 4'd0, 0, 0, 1, 1, 4'd2, 1, 1);
    end
    cyc("ar_stop",   0, 4'd0, 0, 1, 0, 1, 4'd1, 0, 0);
    drain();

    // Enable gating
    cyc("eg_load4",  1, 4'd4, 0, 0, 0, 0, 4'd4, 0, 0);
    cyc("eg_start",  0, 4'd0, 1, 0, 0, 0, 4'd4, 1, 0);
    cyc("eg_en1",    0, 4'd0, 0, 0, 1, 0, 4'd3, 1, 0);
    cyc("eg_en0",    0, 4'd0, 0, 0, 0, 0, 4'd3, 1, 0);
    cyc("eg_en1",    0, 4'd0, 0, 0, 1, 0, 4'd2, 1, 0);
    cyc("eg_en0",    0, 4'd0, 0, 0, 0, 0, 4'd2, 1, 0);
    cyc("eg_en1",    0, 4'd0, 0, 0, 1, 0, 4'd1, 1, 0);
    cyc("eg_en0",    0, 4'd0, 0, 0, 0, 0, 4'd1, 1, 0);
    cyc("eg_expire", 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 1);
    cyc("eg_after",  0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0);
    drain();

    // Load beats stop/start/en while running
    cyc("pr_load6",  1, 4'd6, 0, 0, 0, 0, 4'd6, 0, 0);
    cyc("pr_start",  0, 4'd0, 1, 0, 0, 0, 4'd6, 1, 0);
    cyc("pr_load15", 1, 4'd15, 1, 1, 1, 0, 4'd15, 0, 0);
    cyc("pr_idle",   0, 4'd0, 0, 0, 1, 0, 4'd15, 0, 0);
    // start with cnt==0 is ignored
    cyc("z_load0",   1, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0);
    cyc("z_start",   0, 4'd0, 1, 0, 1, 0, 4'd0, 0, 0);
    cyc("z_start2",  0, 4'd0, 1, 0, 1, 1, 4'd0, 0, 0);
    // stop holds the count, start resumes from it
    cyc("sp_load9",  1, 4'd9, 0, 0, 0, 0, 4'd9, 0, 0);
    cyc("sp_start",  0, 4'd0, 1, 0, 0, 0, 4'd9, 1, 0);
    cyc("sp_stop",   0, 4'd0, 0, 1, 1, 0, 4'd9, 0, 0);
    cyc("sp_idle",   0, 4'd0, 0, 0, 1, 0, 4'd9, 0, 0);
    cyc("sp_resume", 0, 4'd0, 1, 0, 0, 0, 4'd9, 1, 0);
    cyc("sp_dec8",   0, 4'd0, 0, 0, 1, 0, 4'd8, 1, 0);
    cyc("sp_stop2",  0, 4'd0, 0, 1, 0, 0, 4'd8, 0, 0);
    drain();

    // Max value: 15 enabled ticks, every borrow ripple exercised
    cyc("mx_load15", 1, 4'd15, 0, 0, 0, 0, 4'd15, 0, 0);
    cyc("mx_start",  0, 4'd0, 1, 0, 0, 0, 4'd15, 1, 0);
    for (int i = 14; i >= 1; i--) begin
      cyc($sformatf("mx_dec%0d", i), 0, 4'd0, 0, 0, 1, 0, 4'(i), 1, 0);
    end
    cyc("mx_expire", 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 1);
    cyc("mx_after",  0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0);
    drain();

    // Asynchronous reset mid-run at cnt=5
    cyc("rs_load5",  1, 4'd5, 0, 0, 0, 0, 4'd5, 0, 0);
    cyc("rs_start",  0, 4'd0, 1, 0, 0, 0, 4'd5, 1, 0);
    cyc("rs_hold",   0, 4'd0, 0, 0, 0, 0, 4'd5, 1, 0);
    drain();
    load = 1'b0; start = 1'b0; en = 1'b0;
    rst = 1'b1;
    #1;
    check_now("rs_async_clear", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reset kills a done pulse in flight
    cyc("rd_load1",  1, 4'd1, 0, 0, 0, 0, 4'd1, 0, 0);
    cyc("rd_start",  0, 4'd0, 1, 0, 0, 0, 4'd1, 1, 0);
    cyc("rd_expire", 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 1);
    drain();
    load = 1'b0; start = 1'b0; en = 1'b0;
    rst = 1'b1;
    #1;
    check_now("rd_async_clear", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
